// File: rtl/fpu_writeback.sv
// fpu_writeback: write-side sequencer for the FPU register array.
//
// Results from the arithmetic pipe (alu_*) and the load/move unit (mem_*) are
// queued in a DEPTH-entry FIFO and drained one per cycle onto the array's
// write bus. Exception flags accrue into fflags as entries retire.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   alu_valid/ready       arithmetic result handshake; alu_rd/data/flags payload
//   mem_valid/ready       load/move result handshake; mem_rd/data payload
//   stall                 hold the drain for this cycle
//   csr_fflags_we/wdata   CSR write to the accrued flags
//   G                     registered write data
//   F_in                  registered one-hot write enable (bit k writes fk)
//   fflags                accrued NV,DZ,OF,UF,NX
//   count                 FIFO occupancy
//   busy                  work queued or a write on the bus
//
// Handshake: a transfer happens on the rising edge where valid && ready. A
// source holds valid and its payload stable until accepted. ready never looks
// at its own valid, only at FIFO fullness, the other source's valid and the
// round-robin priority. There is no pass-through on full: a dequeue in the
// same cycle does not reopen the FIFO until the next cycle.
module fpu_writeback #(
    parameter int FLEN  = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [FLEN-1:0] alu_data,
    input  logic [4:0]      alu_flags,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [FLEN-1:0] mem_data,
    input  logic            stall,
    input  logic            csr_fflags_we,
    input  logic [4:0]      csr_fflags_wdata,
    output logic [FLEN-1:0] G,
    output logic [31:0]     F_in,
    output logic [4:0]      fflags,
    output logic [AW:0]     count,
    output logic            busy
);

    typedef struct packed {
        logic [4:0]      rd;
        logic [FLEN-1:0] data;
        logic [4:0]      flags;
    } entry_t;

    // Round-robin owner of a contended cycle.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    prio_e           prio_q, prio_d;
    logic [FLEN-1:0] g_q, g_d;
    logic [31:0]     f_in_q, f_in_d;
    logic [4:0]      fflags_q, fflags_d;

    logic   full;
    logic   alu_fire;
    logic   mem_fire;
    logic   push;
    logic   pop;
    entry_t push_entry;
    entry_t head;
    logic [4:0] ret_flags;

    always_comb begin
        full      = (count_q == (AW+1)'(DEPTH));
        alu_ready = !full && (!mem_valid || (prio_q == PRIO_ALU));
        mem_ready = !full && (!alu_valid || (prio_q == PRIO_MEM));
        alu_fire  = alu_valid && alu_ready;
        mem_fire  = mem_valid && mem_ready;
        push      = alu_fire || mem_fire;
        pop       = (count_q != '0) && !stall;
        head      = fifo_q[rd_ptr_q];

        // The two readies are mutually exclusive when both valids are high,
        // so at most one source fires per cycle.
        push_entry = alu_fire ? '{rd: alu_rd, data: alu_data, flags: alu_flags}
                              : '{rd: mem_rd, data: mem_data, flags: 5'b0};

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

        // Priority only rotates after a grant that actually had a loser.
        prio_d = prio_q;
        if (alu_valid && mem_valid && !full) begin
            prio_d = (prio_q == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
        end

        g_d       = g_q;
        f_in_d    = '0;
        ret_flags = '0;
        if (pop) begin
            g_d       = head.data;
            f_in_d    = 32'd1 << head.rd;
            ret_flags = head.flags;
        end

        // A CSR write replaces the accrued value but flags retiring in the
        // same cycle are still ORed in so they are never lost.
        if (csr_fflags_we) begin
            fflags_d = csr_fflags_wdata | ret_flags;
        end else begin
            fflags_d = fflags_q | ret_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= PRIO_ALU;
            g_q      <= '0;
            f_in_q   <= '0;
            fflags_q <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            g_q      <= g_d;
            f_in_q   <= f_in_d;
            fflags_q <= fflags_d;
        end
    end

    assign G      = g_q;
    assign F_in   = f_in_q;
    assign fflags = fflags_q;
    assign count  = count_q;
    assign busy   = (count_q != '0) || (f_in_q != '0);

endmodule
